sample_framer: RTL
==================

# sample_framer

Upstream feeder for the range finder. Accepts a framed sample stream over a valid/ready handshake and buffers it in a small FIFO. Replays each frame as the range finder's `data_in`/`go`/`finish` sequence: a one-cycle `go` with the first sample, one sample per cycle, and `finish` with the last sample. Also absorbs producer stalls, closes malformed frames, and reports framing errors.

## Interface
- `WIDTH`, 8: sample width; matches the range finder's `WIDTH`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 16: underflow cycles before forced close; only used with `SAMPLE_FRAMER_TIMEOUT_EN`.

Ports:
- `clock` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `in_data` input WIDTH: sample.
- `in_valid` input 1: sample present.
- `in_first` input 1: sample opens a frame.
- `in_last` input 1: sample closes a frame.
- `in_ready` output 1: FIFO not full.
- `data_out` output WIDTH: sample to the range finder's `data_in`.
- `go` output 1: one-cycle frame start.
- `finish` output 1: one-cycle frame end.
- `frame_err` output 1: one-cycle framing-error pulse.
- `active` output 1: a frame is open downstream.
- `level` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push occurs when `in_valid & in_ready`. The entry stored is {data, first, last}. `in_ready = (level != DEPTH)`.
- The output FSM states are IDLE, ACTIVE and CLOSE. The FSM pops at most one entry per cycle. All outputs are registered.
- **IDLE, head has first & !last:** pop; emit `data_out`=data and `go`=1; go to ACTIVE.
- **IDLE, head has first & last:** pop; emit `go` with the data; go to CLOSE.
  - `go` and `finish` are never asserted together, because the range finder treats `finish` in IDLE as an error.
- **IDLE, head has !first:** pop and discard; `frame_err`=1; stay in IDLE.
- **CLOSE:** emit `finish`=1 with `data_out` held; go to IDLE. No pop.
- **ACTIVE, head has !first & !last:** pop; emit the data.
- **ACTIVE, head has !first & last:** pop; emit the data with `finish`=1; go to IDLE.
- **ACTIVE, head has first (missing last):** no pop. Emit `finish` with `data_out` held and `frame_err`=1; go to IDLE. The new frame starts the next cycle.
- **ACTIVE, FIFO empty (underflow):** hold `data_out` at the last sample with `go`=`finish`=0. Re-presenting the last sample leaves min/max unchanged.
- `go`, `finish` and `frame_err` are 0 in every cycle not listed above.
- `active` is 1 in ACTIVE and CLOSE.

## Timing
- Reset values: `data_out`=0, `go`=0, `finish`=0, `frame_err`=0, `active`=0, `level`=0, `in_ready`=1. The FIFO is flushed.
- Latency: a sample pushed at edge t appears on `data_out` after edge t+1, provided it is at the FIFO head and the FSM can pop it. There is no write-to-read bypass.
- Back-to-back frames: `finish` in cycle n may be followed by `go` in cycle n+1, since `go` was low in cycle n.
- Simultaneous push and pop: `level` is unchanged.
- A push is never accepted while `level`==DEPTH, even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH.
- Reset mid-frame drops all buffered data and the open frame immediately. The range finder shares `reset`.

## Configuration
- **`SAMPLE_FRAMER_TIMEOUT_EN` defined:** an underflow counter runs in ACTIVE, cleared on every pop.
  - When it reaches TIMEOUT consecutive empty cycles, the framer emits `finish` with the held data and `frame_err`=1, then goes to IDLE.
  - Any orphan samples arriving later are discarded, each with a `frame_err` pulse.
- **Undefined:** ACTIVE holds indefinitely on underflow, and there is no counter logic.

## Structure
- `sample_framer_pkg` holds:
  - the state enum {IDLE, ACTIVE, CLOSE};
  - the FIFO entry struct {data, first, last}, parameterised by width via a localparam default of 8.
- One sub-module, `sample_fifo`: a synchronous FIFO with push, pop, full, empty, level and a registered head.

## Test plan
- **Single frame:** push 5(first), 9, 2(last) back-to-back. Expect `go` with 5, then 9, then `finish` with 2 in consecutive cycles; downstream range = 7.
- **Single-sample frame:** push 7(first, last). Expect `go` with 7, the next cycle `finish` with 7, `go`/`finish` never together; range = 0.
- **Underflow:** push 3(first) and 10, idle 4 cycles, then 1(last). Expect `data_out` held at 10 for 4 cycles, then `finish` with 1; range = 9.
- **Missing last:** push 4(first), 6, 8(first), 2(last). Expect `finish` with 6 plus `frame_err`, then `go` with 8, then `finish` with 2.
- **Full FIFO and orphan:**
  - Stall the consumer and push DEPTH+1 samples; `in_ready`=0 at `level`=4, and the extra sample is not taken.
  - A !first sample in IDLE is discarded with a `frame_err` pulse.
- **Timeout (macro on):** open a frame and starve it 16 cycles. Expect `finish` and `frame_err` on the 16th; reset mid-frame → all outputs 0, `level`=0.

Source files
------------

// File: rtl/sample_framer_pkg.sv
// Shared types for the sample framer: output FSM states and the FIFO entry layout.
package sample_framer_pkg;

  localparam int SAMPLE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    CLOSE
  } state_t;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] data;
    logic                    first;
    logic                    last;
  } entry_t;

endpackage

// File: rtl/sample_framer_fifo.sv
// sample_fifo: synchronous FIFO with push/pop, full/empty, occupancy and a head read
// straight from the storage registers (no write-to-read bypass).
module sample_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; flushing only needs the pointers and level cleared,
  // and leaving the array unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_framer.sv
// sample_framer: buffers a framed sample stream and replays it as go/data/finish for the
// range finder. Optional underflow timeout is enabled with SAMPLE_FRAMER_TIMEOUT_EN.
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     go,
  output logic                     finish,
  output logic                     frame_err,
  output logic                     active,
  output logic [$clog2(DEPTH):0]   level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("sample_framer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  state_t           state;
  logic [WIDTH+1:0] head;
  logic [WIDTH-1:0] head_data;
  logic             head_first;
  logic             head_last;
  logic             full;
  logic             empty;
  logic             pop;

  assign head_data  = head[WIDTH+1:2];
  assign head_first = head[1];
  assign head_last  = head[0];
  assign in_ready   = ~full;

  // A head carrying 'first' while a frame is open stays queued to open the next frame.
  assign pop = ~empty & ((state == IDLE) | ((state == ACTIVE) & ~head_first));

  sample_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid),
    .push_data ({in_data, in_first, in_last}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

`ifdef SAMPLE_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] starve_count;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      data_out  <= '0;
      go        <= 1'b0;
      finish    <= 1'b0;
      frame_err <= 1'b0;
      active    <= 1'b0;
`ifdef SAMPLE_FRAMER_TIMEOUT_EN
      starve_count <= '0;
`endif
    end else begin
      go        <= 1'b0;
      finish    <= 1'b0;
      frame_err <= 1'b0;
`ifdef SAMPLE_FRAMER_TIMEOUT_EN
      starve_count <= '0;
`endif
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head_first) begin
              data_out <= head_data;
              go       <= 1'b1;
              active   <= 1'b1;
              // finish for a one-sample frame is deferred so it never coincides with go
              state    <= head_last ? CLOSE : ACTIVE;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        CLOSE: begin
          finish <= 1'b1;
          active <= 1'b0;
          state  <= IDLE;
        end
        ACTIVE: begin
          if (!empty) begin
            if (head_first) begin
              finish    <= 1'b1;
              frame_err <= 1'b1;
              active    <= 1'b0;
              state     <= IDLE;
            end else begin
              data_out <= head_data;
              if (head_last) begin
                finish <= 1'b1;
                active <= 1'b0;
                state  <= IDLE;
              end
            end
          end
`ifdef SAMPLE_FRAMER_TIMEOUT_EN
          else if (starve_count == TIMEOUT_LAST) begin
            finish    <= 1'b1;
            frame_err <= 1'b1;
            active    <= 1'b0;
            state     <= IDLE;
          end else begin
            starve_count <= starve_count + 1'b1;
          end
`endif
        end
        default: begin
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
